// File: rtl/seg_pkg.sv
// Shared constants, phase type and parameter legality check for the
// seven-segment scan controller and its digit decoder.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         BCD_W     = 4;

    typedef enum logic {
        PH_GAP,
        PH_SHOW
    } phase_t;

    function automatic bit params_ok(input int num_digits, input int refresh_div,
                                     input int blank_cycles);
        return (num_digits >= 2) && (num_digits <= 8) && (refresh_div >= 4) &&
               (blank_cycles >= 1) && (blank_cycles < refresh_div);
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD to active-low seven-segment (gfedcba) decoder; codes 10..15 are dark.
module seven_seg_decoder
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed common-anode display scanner with blank gap per slot and
// frame-boundary commit of staged digit data (no tearing).
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          frame_done,
    output logic                          pending
);

    localparam int                    CNT_W    = $clog2(REFRESH_DIV);
    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GAP_END  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    if (!params_ok(NUM_DIGITS, REFRESH_DIV, BLANK_CYCLES)) begin : g_bad_params
        $error("seg_scan_controller: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
    end

    logic [CNT_W-1:0]                  cnt, cnt_nxt;
    logic [IDX_W-1:0]                  idx, idx_nxt;
    phase_t                            phase;
    logic                              slot_end, frame_wrap;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]  stg_d, shd_d;
    logic [NUM_DIGITS-1:0]             stg_b, shd_b;
    logic [BCD_W-1:0]                  cur_bcd;
    logic [6:0]                        dec_seg;
    logic [NUM_DIGITS-1:0]             an_nxt;
    logic [6:0]                        seg_nxt;

    assign cur_bcd = shd_d[idx];

    seven_seg_decoder u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        phase      = (cnt < GAP_END) ? PH_GAP : PH_SHOW;
        slot_end   = (cnt == CNT_LAST);
        frame_wrap = en && slot_end && (idx == IDX_LAST);
        cnt_nxt    = cnt + 1'b1;
        idx_nxt    = idx;
        an_nxt     = AN_OFF;
        seg_nxt    = SEG_BLANK;

        if (!en) begin
            cnt_nxt = '0;
            idx_nxt = '0;
        end else if (slot_end) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end

        if (en && (phase == PH_SHOW)) begin
            an_nxt = ~(AN_ONE << idx);
            if (!shd_b[idx]) seg_nxt = dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: staging and shadow are reset as well so a cold board shows dark digits, not garbage.
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
            pending    <= 1'b0;
            stg_d      <= '1;
            stg_b      <= '1;
            shd_d      <= '1;
            shd_b      <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= frame_wrap;

            // A load landing on the wrap skips staging so it is not held a whole frame.
            if (load) begin
                stg_d <= digits_in;
                stg_b <= blank_in;
                if (frame_wrap) begin
                    shd_d   <= digits_in;
                    shd_b   <= blank_in;
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (pending && (frame_wrap || !en)) begin
                shd_d   <= stg_d;
                shd_b   <= stg_b;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller (4 digits, 8-cycle slots, 2-cycle gap).
module tb_seg_scan_controller;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            load;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]   blank_in;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            frame_done;
    logic            pending;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .blank_in   (blank_in),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .pending    (pending)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0]     d;
        logic [3:0]      b;
        logic [3:0][6:0] segs;
    } vec_t;

    exp_t            sb[$];
    vec_t            vecs[6];
    int              errors = 0;
    int              checks = 0;
    int              g_s;
    logic [3:0][6:0] disp_seg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0][6:0] disp_of(input logic [15:0] d, input logic [3:0] b);
        logic [3:0][6:0] r;
        for (int i = 0; i < 4; i++) r[i] = b[i] ? 7'h7F : enc(d[4*i +: 4]);
        return r;
    endfunction

    // Expected pins for sample s counted from the first enabled edge.
    function automatic exp_t scan_exp(input int s);
        exp_t e;
        int   p    = s % RD;
        int   slot = (s / RD) % ND;
        e.fd = ((s + 1) % (RD * ND)) == 0;
        if (p < BC) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
        end else begin
            e.an  = ~(4'b0001 << slot);
            e.seg = disp_seg[slot];
        end
        return e;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e = sb.pop_front();
        check({tag, " an"},  32'(an),         32'(e.an));
        check({tag, " seg"}, 32'(seg),        32'(e.seg));
        check({tag, " fd"},  32'(frame_done), 32'(e.fd));
    endtask

    task automatic step_scan();
        sb.push_back(scan_exp(g_s));
        tick();
        compare_out($sformatf("scan s=%0d", g_s));
        g_s++;
    endtask

    task automatic step_dark(input string tag);
        exp_t e;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.fd  = 1'b0;
        sb.push_back(e);
        tick();
        compare_out(tag);
    endtask

    task automatic load_while_dark(input logic [15:0] d, input logic [3:0] b);
        digits_in = d;
        blank_in  = b;
        load      = 1'b1;
        step_dark("dark load");
        check("pending after idle load", 32'(pending), 32'(1));
        load = 1'b0;
        step_dark("dark commit");
        check("pending after idle commit", 32'(pending), 32'(0));
    endtask

    task automatic load_scan(input logic [15:0] d, input logic [3:0] b);
        digits_in = d;
        blank_in  = b;
        load      = 1'b1;
        step_scan();
        load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h4321, 4'b0000, {7'h19, 7'h30, 7'h24, 7'h79}};
        vecs[1] = '{16'h9999, 4'b0000, {7'h10, 7'h10, 7'h10, 7'h10}};
        vecs[2] = '{16'h4321, 4'b0100, {7'h19, 7'h7F, 7'h24, 7'h79}};
        vecs[3] = '{16'h0C50, 4'b0000, {7'h40, 7'h7F, 7'h12, 7'h40}};
        vecs[4] = '{16'hFEDA, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[5] = '{16'h8765, 4'b1001, {7'h7F, 7'h78, 7'h02, 7'h7F}};

        rst       = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        blank_in  = '0;
        #2;
        check("reset an",      32'(an),         32'hF);
        check("reset seg",     32'(seg),        32'h7F);
        check("reset fd",      32'(frame_done), 32'(0));
        check("reset pending", 32'(pending),    32'(0));
        repeat (2) tick();
        rst = 1'b0;

        // Table vectors: load while dark, then scan one full frame.
        for (int i = 0; i < 6; i++) begin
            load_while_dark(vecs[i].d, vecs[i].b);
            en       = 1'b1;
            g_s      = 0;
            disp_seg = vecs[i].segs;
            repeat (RD * ND) step_scan();
            en = 1'b0;
            step_dark("dark after vector");
        end

        // Tear-free commit: load mid-frame, old digits hold until the wrap.
        load_while_dark(16'h4321, 4'b0000);
        en       = 1'b1;
        g_s      = 0;
        disp_seg = disp_of(16'h4321, 4'b0000);
        while (g_s < 10) step_scan();
        load_scan(16'h9999, 4'b0000);
        check("pending after mid-frame load", 32'(pending), 32'(1));
        while (g_s < 31) step_scan();
        check("pending before wrap", 32'(pending), 32'(1));
        step_scan();
        check("pending after wrap", 32'(pending), 32'(0));
        disp_seg = disp_of(16'h9999, 4'b0000);
        while (g_s < 66) step_scan();

        // Two loads in one frame: last write wins.
        load_scan(16'h5555, 4'b0000);
        while (g_s < 70) step_scan();
        load_scan(16'h0707, 4'b0000);
        check("pending after second load", 32'(pending), 32'(1));
        while (g_s < 96) step_scan();
        check("pending after overwrite commit", 32'(pending), 32'(0));
        disp_seg = disp_of(16'h0707, 4'b0000);
        while (g_s < 127) step_scan();

        // Load in the wrap cycle goes straight to the shadow.
        load_scan(16'h6868, 4'b0000);
        check("pending after bypass load", 32'(pending), 32'(0));
        disp_seg = disp_of(16'h6868, 4'b0000);
        while (g_s < 134) step_scan();
        check("pending still clear after bypass", 32'(pending), 32'(0));

        // Drop en mid-slot, then restart from idx 0 gap.
        en = 1'b0;
        step_dark("en low 1");
        step_dark("en low 2");
        step_dark("en low 3");
        en  = 1'b1;
        g_s = 0;
        repeat (12) step_scan();

        // Async reset mid-SHOW discards a staged load.
        load_scan(16'h5555, 4'b0000);
        check("pending before reset", 32'(pending), 32'(1));
        #3;
        rst = 1'b1;
        #1;
        check("async reset an",      32'(an),         32'hF);
        check("async reset seg",     32'(seg),        32'h7F);
        check("async reset fd",      32'(frame_done), 32'(0));
        check("async reset pending", 32'(pending),    32'(0));
        tick();
        rst      = 1'b0;
        g_s      = 0;
        disp_seg = disp_of(16'hFFFF, 4'b1111);
        repeat (40) step_scan();
        check("pending after reset frame", 32'(pending), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
